// File: rtl/fp_align_add.sv
// FP16 add/sub alignment stage: orders operands by magnitude, aligns the smaller
// mantissa with a 1-bit/cycle serial shifter, then adds or subtracts.
// Optional sticky output is enabled with the FP_ALIGN_STICKY_EN macro.
module fp_align_add #(
  parameter int EW        = 5,
  parameter int MW        = 11,
  parameter int MAX_SHIFT = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          sa,
  input  logic [EW-1:0] ea,
  input  logic [MW-1:0] ma,
  input  logic          sb,
  input  logic [EW-1:0] eb,
  input  logic [MW-1:0] mb,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          sr,
  output logic [EW-1:0] er,
  output logic [MW:0]   mr
`ifdef FP_ALIGN_STICKY_EN
  ,
  output logic          sticky
`endif
);

  localparam int CW = $clog2(MAX_SHIFT + 1);

  typedef enum logic [1:0] {IDLE, ALIGN, ADD, DONE} state_t;

  state_t        state;
  logic          s_big;
  logic          eff_sub;
  logic [EW-1:0] e_big;
  logic [MW-1:0] m_big;
  logic [MW-1:0] sh;
  logic [CW-1:0] cnt;
`ifdef FP_ALIGN_STICKY_EN
  logic          sticky_acc;
`endif

  logic          a_big;
  logic [EW-1:0] diff;
  logic [MW-1:0] m_small_in;
  logic          clamp;
  logic [MW:0]   sum;

  // On a full tie A is taken as the larger operand.
  assign a_big      = (ea > eb) || ((ea == eb) && (ma >= mb));
  assign diff       = a_big ? (ea - eb) : (eb - ea);
  assign m_small_in = a_big ? mb : ma;
  assign clamp      = int'(diff) >= MAX_SHIFT;

  // Unequal signs never go negative: m_big >= sh because big was ordered by magnitude.
  assign sum = eff_sub ? ({1'b0, m_big} - {1'b0, sh})
                       : ({1'b0, m_big} + {1'b0, sh});

  // NOTE: all state is updated with non-blocking assignments in one clocked block,
  // so every register sees the values from before this edge regardless of order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      s_big     <= 1'b0;
      eff_sub   <= 1'b0;
      e_big     <= '0;
      m_big     <= '0;
      sh        <= '0;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sr        <= 1'b0;
      er        <= '0;
      mr        <= '0;
`ifdef FP_ALIGN_STICKY_EN
      sticky_acc <= 1'b0;
      sticky     <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            s_big    <= a_big ? sa : sb;
            e_big    <= a_big ? ea : eb;
            m_big    <= a_big ? ma : mb;
            eff_sub  <= sa ^ sb;
            // Clamped gaps load a zero shifter but still count MAX_SHIFT cycles,
            // keeping the latency at min(gap, MAX_SHIFT) + 2.
            sh       <= clamp ? '0 : m_small_in;
            cnt      <= clamp ? CW'(MAX_SHIFT) : CW'(diff);
`ifdef FP_ALIGN_STICKY_EN
            sticky_acc <= clamp ? |m_small_in : 1'b0;
`endif
            in_ready <= 1'b0;
            state    <= ALIGN;
          end
        end
        ALIGN: begin
          if (cnt == '0) begin
            state <= ADD;
          end else begin
            sh  <= sh >> 1;
            cnt <= cnt - 1'b1;
`ifdef FP_ALIGN_STICKY_EN
            sticky_acc <= sticky_acc | sh[0];
`endif
          end
        end
        ADD: begin
          mr        <= sum;
          sr        <= (sum == '0) ? 1'b0 : s_big;
          er        <= e_big;
`ifdef FP_ALIGN_STICKY_EN
          sticky    <= sticky_acc;
`endif
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_align_add.sv
// Self-checking bench for fp_align_add: directed test-plan vectors, backpressure,
// reset during ALIGN, and randomized operands against an arithmetic reference model.
module tb_fp_align_add;

  localparam int EW = 5;
  localparam int MW = 11;
  localparam int MAX_SHIFT = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          sa, sb;
  logic [EW-1:0] ea, eb;
  logic [MW-1:0] ma, mb;
  logic          out_valid;
  logic          out_ready;
  logic          sr;
  logic [EW-1:0] er;
  logic [MW:0]   mr;
`ifdef FP_ALIGN_STICKY_EN
  logic          sticky;
`endif

  int passed = 0;
  int total  = 0;
  int failed = 0;

  fp_align_add #(.EW(EW), .MW(MW), .MAX_SHIFT(MAX_SHIFT)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sa        (sa),
    .ea        (ea),
    .ma        (ma),
    .sb        (sb),
    .eb        (eb),
    .mb        (mb),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sr        (sr),
    .er        (er),
    .mr        (mr)
`ifdef FP_ALIGN_STICKY_EN
    ,
    .sticky    (sticky)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the magnitude-ordered operands.
  task automatic model(input logic a_s, input int a_e, input int a_m,
                       input logic b_s, input int b_e, input int b_m,
                       output int x_sr, output int x_er, output int x_mr,
                       output int x_sticky, output int x_lat);
    bit a_is_big;
    int gap, d, big_m, small_m, shifted, big_s, big_e;
    a_is_big = (a_e > b_e) || (a_e == b_e && a_m >= b_m);
    gap      = (a_e > b_e) ? a_e - b_e : b_e - a_e;
    d        = (gap > MAX_SHIFT) ? MAX_SHIFT : gap;
    big_m    = a_is_big ? a_m : b_m;
    small_m  = a_is_big ? b_m : a_m;
    big_s    = a_is_big ? int'(a_s) : int'(b_s);
    big_e    = a_is_big ? a_e : b_e;
    shifted  = small_m / (1 << d);
    x_sticky = (small_m % (1 << d)) != 0 ? 1 : 0;
    x_mr     = (a_s == b_s) ? big_m + shifted : big_m - shifted;
    x_sr     = (x_mr == 0) ? 0 : big_s;
    x_er     = big_e;
    x_lat    = d + 2;
  endtask

  task automatic run_op(input string tag,
                        input logic a_s, input logic [EW-1:0] a_e, input logic [MW-1:0] a_m,
                        input logic b_s, input logic [EW-1:0] b_e, input logic [MW-1:0] b_m,
                        input int hold);
    int x_sr, x_er, x_mr, x_sticky, x_lat, lat, wait_cnt;
    logic [31:0] snap;
    model(a_s, int'(a_e), int'(a_m), b_s, int'(b_e), int'(b_m),
          x_sr, x_er, x_mr, x_sticky, x_lat);
    wait_cnt = 0;
    while (!in_ready && wait_cnt < 40) begin
      @(posedge clk); #1;
      wait_cnt++;
    end
    check({tag, " in_ready before accept"}, 32'(in_ready), 32'd1);
    sa = a_s; ea = a_e; ma = a_m;
    sb = b_s; eb = b_e; mb = b_m;
    in_valid = 1'b1;
    @(posedge clk); #1;
    // Garbage after the accepting edge must not affect the result.
    in_valid = 1'b0;
    sa = 1'($urandom); ea = EW'($urandom); ma = MW'($urandom);
    sb = 1'($urandom); eb = EW'($urandom); mb = MW'($urandom);
    check({tag, " in_ready low after accept"}, 32'(in_ready), 32'd0);
    lat = 1;
    while (lat < 40) begin
      @(posedge clk); #1;
      // Drive in_valid while busy; it must be ignored.
      in_valid = 1'b1;
      if (out_valid) break;
      lat++;
    end
    in_valid = 1'b0;
    check({tag, " latency"}, 32'(lat), 32'(x_lat));
    check({tag, " sr"}, 32'(sr), 32'(x_sr));
    check({tag, " er"}, 32'(er), 32'(x_er));
    check({tag, " mr"}, 32'(mr), 32'(x_mr));
`ifdef FP_ALIGN_STICKY_EN
    check({tag, " sticky"}, 32'(sticky), 32'(x_sticky));
`endif
    snap = {16'd0, out_valid, in_ready, sr, er, mr};
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, " held in DONE"}, {16'd0, out_valid, in_ready, sr, er, mr}, snap);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
    check({tag, " in_ready back"}, 32'(in_ready), 32'd1);
    check({tag, " result kept"}, {16'd0, sr, er, mr}, {16'd0, 1'(x_sr), EW'(x_er), (MW+1)'(x_mr)});
  endtask

  initial begin
    logic          r_sa, r_sb;
    int            r_ea, r_eb;
    logic [MW-1:0] r_ma, r_mb;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    sa = 1'b0; ea = '0; ma = '0; sb = 1'b0; eb = '0; mb = '0;
    #12;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset result", {16'd0, sr, er, mr}, 32'd0);
`ifdef FP_ALIGN_STICKY_EN
    check("reset sticky", 32'(sticky), 32'd0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("1.0+1.0",  1'b0, 5'd15, 11'h400, 1'b0, 5'd15, 11'h400, 0);
    run_op("1.0+0.5",  1'b0, 5'd15, 11'h400, 1'b0, 5'd14, 11'h400, 0);
    run_op("-2.0+1.0", 1'b1, 5'd16, 11'h400, 1'b0, 5'd15, 11'h400, 0);
    run_op("1.0-1.0",  1'b0, 5'd15, 11'h400, 1'b1, 5'd15, 11'h400, 0);
    run_op("large gap", 1'b0, 5'd30, 11'h401, 1'b0, 5'd1, 11'h7FF, 0);
    run_op("B bigger mant", 1'b0, 5'd7, 11'h455, 1'b1, 5'd7, 11'h5AA, 0);
    run_op("backpressure", 1'b1, 5'd3, 11'h7FF, 1'b1, 5'd0, 11'h7FF, 5);

    // Reset pulsed in the middle of ALIGN abandons the operation.
    in_valid = 1'b1;
    sa = 1'b0; ea = 5'd20; ma = 11'h600; sb = 1'b0; eb = 5'd10; mb = 11'h500;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    check("rst mid-ALIGN out_valid", 32'(out_valid), 32'd0);
    check("rst mid-ALIGN in_ready", 32'(in_ready), 32'd1);
    #1 rst = 1'b0;
    repeat (16) begin @(posedge clk); #1; end
    check("no output after abandon", 32'(out_valid), 32'd0);
    run_op("after reset", 1'b0, 5'd20, 11'h600, 1'b1, 5'd18, 11'h7C3, 0);

    for (int n = 0; n < 40; n++) begin
      r_sa = 1'($urandom); r_sb = 1'($urandom);
      r_ma = {1'b1, 10'($urandom)};
      r_mb = (n % 5 == 0) ? r_ma : {1'b1, 10'($urandom)};
      r_ea = int'($urandom_range(0, 31));
      if (n % 2 == 0) r_eb = int'($urandom_range(0, 31));
      else begin
        r_eb = r_ea + int'($urandom_range(0, 8)) - 4;
        if (r_eb < 0) r_eb = 0;
        if (r_eb > 31) r_eb = 31;
      end
      run_op($sformatf("rand%0d", n), r_sa, EW'(r_ea), r_ma, r_sb, EW'(r_eb), r_mb,
             int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
